call_stack: RTL and testbench
=============================

CALL_STACK -- requirements
Module: call_stack

Interface
REQ-001: Parameter DATA_W, default 12: entry width in bits, min 1.
REQ-002: Parameter DEPTH, default 8: entry count, power of two, min 2.
REQ-003: Parameter AFULL_LVL, default DEPTH-1: count at or above which STACK_AFULL asserts, range 1..DEPTH.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: PushEnbl  input  1  push request, sampled each clk.
REQ-007: PopEnbl  input  1  pop request, sampled each clk.
REQ-008: PushDataIn  input  DATA_W  data to push.
REQ-009: PopDataOut  output  DATA_W  registered last-popped entry.
REQ-010: STACK_FULL  output  1  count == DEPTH.
REQ-011: STACK_EMPTY  output  1  count == 0.
REQ-012: STACK_AFULL  output  1  count >= AFULL_LVL.
REQ-013: Depth_Cnt  output  clog2(DEPTH+1)  current occupancy.
REQ-014: Ovf_Err  output  1  sticky overflow flag.
REQ-015: Unf_Err  output  1  sticky underflow flag.

Function
REQ-016: Push only, not full: store PushDataIn at index Depth_Cnt, count +1; visible next cycle.
REQ-017: Pop only, not empty: PopDataOut <= entry at index Depth_Cnt-1, count -1; latency one clk.
REQ-018: PopDataOut holds its value on every cycle without an accepted pop.
REQ-019: Push+pop, not empty: PopDataOut <= current top, top overwritten with PushDataIn, count unchanged, no error (applies when full).
REQ-020: Push+pop, empty: PopDataOut <= PushDataIn (bypass), count stays 0, no storage write, Unf_Err unchanged.
REQ-021: Push only when full: write dropped, count unchanged, Ovf_Err <= 1.
REQ-022: Pop only when empty: PopDataOut holds, count stays 0, Unf_Err <= 1.
REQ-023: STACK_FULL, STACK_EMPTY, STACK_AFULL decoded combinationally from the registered count only; no path from PushEnbl/PopEnbl.
REQ-024: Count never wraps; storage index is Depth_Cnt, no separate pointer.
REQ-025: Ovf_Err/Unf_Err once set remain 1 until reset (or Err_Clr per REQ-030).

Reset
REQ-026: reset asserted: Depth_Cnt=0, PopDataOut=0, Ovf_Err=0, Unf_Err=0 immediately, independent of clk.
REQ-027: Storage array not reset; unwritten entries unobservable since empty pops are blocked.
REQ-028: reset mid-operation discards all contents; first cycle after release behaves as empty stack; requests coincident with reset ignored.

Configuration
REQ-029: Macro CALL_STACK_ERR_CLR_EN selects error-clear feature.
REQ-030: Defined: extra input Err_Clr (1 bit); Err_Clr=1 clears Ovf_Err and Unf_Err next clk; a same-cycle error event wins (flag ends 1).
REQ-031: Undefined: no Err_Clr port; flags clear only by reset.

Structure
REQ-032: Package call_stack_pkg holds default DATA_W/DEPTH constants and a count-width function clog2(DEPTH+1).
REQ-033: One sub-module stack_mem: DEPTH x DATA_W register array, one write port, one async read port at Depth_Cnt-1; control and flags in call_stack.

Verification
REQ-034: DATA_W=12, DEPTH=8; push 0x001..0x008 -> STACK_FULL=1, Depth_Cnt=8, STACK_AFULL from count 7.
REQ-035: Then 8 pops -> PopDataOut 0x008..0x001 one clk after each pop, STACK_EMPTY=1 after last.
REQ-036: Pop on empty -> Unf_Err=1, PopDataOut holds 0x001; 9th push on full -> Ovf_Err=1, Depth_Cnt stays 8, top unchanged.
REQ-037: Push 0x0AA+pop, count 3 with top 0x003 -> PopDataOut=0x003, count 3, next pop returns 0x0AA; same on empty -> PopDataOut=0x0AA, count 0.
REQ-038: Assert reset mid-clk with count 5 and Ovf_Err=1 -> Depth_Cnt, flags, PopDataOut 0 before next edge.
REQ-039: With CALL_STACK_ERR_CLR_EN, Err_Clr with coincident overflow -> Ovf_Err stays 1; Err_Clr alone next cycle -> 0.

Source files
------------

// File: rtl/call_stack_pkg.sv
// Shared constants, request decode and sizing helper for the call stack.
package call_stack_pkg;

    localparam int DEFAULT_DATA_W = 12;
    localparam int DEFAULT_DEPTH  = 8;

    // Request decode for one cycle: {PushEnbl, PopEnbl}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

    // Occupancy counter width: must represent 0..depth inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Entry storage for the call stack: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset; the
// controller never reads an entry that has not been written.
module stack_mem
    import call_stack_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write the addressed entry when the controller accepts a push or swap
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem_q[wrAddr] <= wrData;
        end
    end

    assign rdData = mem_q[rdAddr];

endmodule

// File: rtl/call_stack.sv
// LIFO call stack with occupancy count, derived flags and sticky
// overflow/underflow errors. The occupancy count doubles as the write
// index, so no separate pointer exists.
// Optional feature: define CALL_STACK_ERR_CLR_EN to add the Err_Clr input
// that clears both sticky error flags.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AFULL_LVL = DEPTH - 1
) (
    input  logic                        clk,
    input  logic                        reset,
`ifdef CALL_STACK_ERR_CLR_EN
    input  logic                        Err_Clr,
`endif
    input  logic                        PushEnbl,
    input  logic                        PopEnbl,
    input  logic [DATA_W-1:0]           PushDataIn,
    output logic [DATA_W-1:0]           PopDataOut,
    output logic                        STACK_FULL,
    output logic                        STACK_EMPTY,
    output logic                        STACK_AFULL,
    output logic [cnt_width(DEPTH)-1:0] Depth_Cnt,
    output logic                        Ovf_Err,
    output logic                        Unf_Err
);

    localparam int CNT_W  = cnt_width(DEPTH);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] popData_q, popData_d;
    logic              ovfErr_q, ovfErr_d;
    logic              unfErr_q, unfErr_d;

    stack_op_e         op;
    logic              isFull, isEmpty;
    logic              ovfEvt, unfEvt, errClr;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr, rdAddr;
    logic [DATA_W-1:0] rdData;

    // Flags come only from the registered count, never from the requests
    assign isFull      = (cnt_q == CNT_W'(DEPTH));
    assign isEmpty     = (cnt_q == '0);
    assign STACK_FULL  = isFull;
    assign STACK_EMPTY = isEmpty;
    assign STACK_AFULL = (cnt_q >= CNT_W'(AFULL_LVL));
    assign Depth_Cnt   = cnt_q;
    assign PopDataOut  = popData_q;
    assign Ovf_Err     = ovfErr_q;
    assign Unf_Err     = unfErr_q;

    // Top of stack sits one below the count; the value is unused when empty
    assign rdAddr = ADDR_W'(cnt_q - 1'b1);

`ifdef CALL_STACK_ERR_CLR_EN
    assign errClr = Err_Clr;
`else
    assign errClr = 1'b0;
`endif

    // Decode the two request lines into a single operation
    always_comb begin
        case ({PushEnbl, PopEnbl})
            2'b01:   op = OP_POP;
            2'b10:   op = OP_PUSH;
            2'b11:   op = OP_SWAP;
            default: op = OP_IDLE;
        endcase
    end

    // Next-state logic: swap replaces the top in place, or bypasses when empty
    always_comb begin
        cnt_d     = cnt_q;
        popData_d = popData_q;
        wrEn      = 1'b0;
        wrAddr    = ADDR_W'(cnt_q);
        ovfEvt    = 1'b0;
        unfEvt    = 1'b0;
        case (op)
            OP_PUSH: begin
                if (isFull) begin
                    ovfEvt = 1'b1;
                end else begin
                    wrEn  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OP_POP: begin
                if (isEmpty) begin
                    unfEvt = 1'b1;
                end else begin
                    popData_d = rdData;
                    cnt_d     = cnt_q - 1'b1;
                end
            end
            OP_SWAP: begin
                if (isEmpty) begin
                    popData_d = PushDataIn;
                end else begin
                    popData_d = rdData;
                    wrEn      = 1'b1;
                    wrAddr    = rdAddr;
                end
            end
            default: ;
        endcase
        ovfErr_d = (ovfErr_q & ~errClr) | ovfEvt;
        unfErr_d = (unfErr_q & ~errClr) | unfEvt;
    end

    // Control state with immediate clear on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            popData_q <= '0;
            ovfErr_q  <= 1'b0;
            unfErr_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            popData_q <= popData_d;
            ovfErr_q  <= ovfErr_d;
            unfErr_q  <= unfErr_d;
        end
    end

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (wrAddr),
        .wrData (PushDataIn),
        .rdAddr (rdAddr),
        .rdData (rdData)
    );

endmodule

// File: tb/tb_call_stack.sv
// Testbench for call_stack (DATA_W=12, DEPTH=8). A queue-based stack model
// is checked against every output on each falling edge, and hand-computed
// literals pin the model at key points of the directed sequence.
module tb_call_stack;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PushEnbl = 1'b0;
    logic        PopEnbl = 1'b0;
    logic [11:0] PushDataIn = '0;
    logic [11:0] PopDataOut;
    logic        STACK_FULL, STACK_EMPTY, STACK_AFULL;
    logic [3:0]  Depth_Cnt;
    logic        Ovf_Err, Unf_Err;
`ifdef CALL_STACK_ERR_CLR_EN
    logic        Err_Clr = 1'b0;
`endif

    int compCount = 0;
    int failCount = 0;
    bit checkEn = 1'b0;

    logic [11:0] stk[$];
    logic [11:0] mPop = '0;
    bit          mOvf = 1'b0;
    bit          mUnf = 1'b0;
    bit          ovfEv, unfEv, clrNow;

    call_stack #(.DATA_W(12), .DEPTH(8), .AFULL_LVL(7)) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef CALL_STACK_ERR_CLR_EN
        .Err_Clr     (Err_Clr),
`endif
        .PushEnbl    (PushEnbl),
        .PopEnbl     (PopEnbl),
        .PushDataIn  (PushDataIn),
        .PopDataOut  (PopDataOut),
        .STACK_FULL  (STACK_FULL),
        .STACK_EMPTY (STACK_EMPTY),
        .STACK_AFULL (STACK_AFULL),
        .Depth_Cnt   (Depth_Cnt),
        .Ovf_Err     (Ovf_Err),
        .Unf_Err     (Unf_Err)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // One comparison: count it, report it when it differs
    task automatic checkOutput(input string name, input int actual, input int expected);
        compCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural stack model: plain queue semantics from the request rules
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stk.delete();
            mPop = '0;
            mOvf = 1'b0;
            mUnf = 1'b0;
        end else begin
            ovfEv  = 1'b0;
            unfEv  = 1'b0;
            clrNow = 1'b0;
`ifdef CALL_STACK_ERR_CLR_EN
            clrNow = Err_Clr;
`endif
            if (PushEnbl && PopEnbl) begin
                if (stk.size() == 0) begin
                    mPop = PushDataIn;
                end else begin
                    mPop = stk[stk.size() - 1];
                    stk[stk.size() - 1] = PushDataIn;
                end
            end else if (PushEnbl) begin
                if (stk.size() == 8) ovfEv = 1'b1;
                else stk.push_back(PushDataIn);
            end else if (PopEnbl) begin
                if (stk.size() == 0) unfEv = 1'b1;
                else mPop = stk.pop_back();
            end
            if (clrNow) begin
                mOvf = 1'b0;
                mUnf = 1'b0;
            end
            if (ovfEv) mOvf = 1'b1;
            if (unfEv) mUnf = 1'b1;
        end
    end

    // Compare every output against the model away from the rising edge
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model Depth_Cnt", int'(Depth_Cnt), stk.size());
            checkOutput("model PopDataOut", int'(PopDataOut), int'(mPop));
            checkOutput("model STACK_FULL", int'(STACK_FULL), int'(stk.size() == 8));
            checkOutput("model STACK_EMPTY", int'(STACK_EMPTY), int'(stk.size() == 0));
            checkOutput("model STACK_AFULL", int'(STACK_AFULL), int'(stk.size() >= 7));
            checkOutput("model Ovf_Err", int'(Ovf_Err), int'(mOvf));
            checkOutput("model Unf_Err", int'(Unf_Err), int'(mUnf));
        end
    end

    // Present one request across a rising edge, then return to idle
    task automatic applyStimulus(input bit push, input bit pop, input logic [11:0] data);
        @(negedge clk);
        PushEnbl   = push;
        PopEnbl    = pop;
        PushDataIn = data;
        @(posedge clk);
        #1;
        PushEnbl = 1'b0;
        PopEnbl  = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        // Requests during reset must be ignored
        PushEnbl   = 1'b1;
        PushDataIn = 12'h0FF;
        checkEn    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset Depth_Cnt", int'(Depth_Cnt), 0);
        checkOutput("reset STACK_EMPTY", int'(STACK_EMPTY), 1);
        checkOutput("reset PopDataOut", int'(PopDataOut), 0);
        PushEnbl = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;

        // Fill to full; almost-full from count 7
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 12'(i));
            checkOutput($sformatf("fill count %0d", i), int'(Depth_Cnt), i);
            checkOutput($sformatf("fill afull %0d", i), int'(STACK_AFULL), (i >= 7) ? 1 : 0);
        end
        checkOutput("full flag", int'(STACK_FULL), 1);

        // Push on full: dropped, overflow sticky
        applyStimulus(1'b1, 1'b0, 12'h009);
        checkOutput("ovf flag", int'(Ovf_Err), 1);
        checkOutput("ovf count held", int'(Depth_Cnt), 8);

        // Drain in LIFO order; top was not overwritten by the dropped push
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, 1'b1, 12'h000);
            checkOutput($sformatf("drain pop %0d", i), int'(PopDataOut), 9 - i);
        end
        checkOutput("drained empty", int'(STACK_EMPTY), 1);

        // Pop on empty: output holds, underflow sticky
        applyStimulus(1'b0, 1'b1, 12'h000);
        checkOutput("unf flag", int'(Unf_Err), 1);
        checkOutput("unf pop held", int'(PopDataOut), 12'h001);

        // Swap with three entries, then drain, then bypass swap on empty
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 1'b0, 12'(i));
        applyStimulus(1'b1, 1'b1, 12'h0AA);
        checkOutput("swap pop", int'(PopDataOut), 12'h003);
        checkOutput("swap count", int'(Depth_Cnt), 3);
        applyStimulus(1'b0, 1'b1, 12'h000);
        checkOutput("pop swapped top", int'(PopDataOut), 12'h0AA);
        applyStimulus(1'b0, 1'b1, 12'h000);
        applyStimulus(1'b0, 1'b1, 12'h000);
        checkOutput("pop after swap", int'(PopDataOut), 12'h001);
        applyStimulus(1'b1, 1'b1, 12'h0AA);
        checkOutput("bypass pop", int'(PopDataOut), 12'h0AA);
        checkOutput("bypass count", int'(Depth_Cnt), 0);

        // Mid-cycle reset with five entries and overflow still set
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 12'h010 + 12'(i));
        checkOutput("pre-reset count", int'(Depth_Cnt), 5);
        checkOutput("pre-reset ovf", int'(Ovf_Err), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset count", int'(Depth_Cnt), 0);
        checkOutput("async reset ovf", int'(Ovf_Err), 0);
        checkOutput("async reset unf", int'(Unf_Err), 0);
        checkOutput("async reset pop", int'(PopDataOut), 0);
        PushEnbl   = 1'b1;
        PushDataIn = 12'h055;
        @(posedge clk);
        #1 PushEnbl = 1'b0;
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post-reset empty", int'(STACK_EMPTY), 1);

        // Swap while full: no overflow, count unchanged
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 12'h020 + 12'(i));
        applyStimulus(1'b1, 1'b1, 12'h0CC);
        checkOutput("full swap pop", int'(PopDataOut), 12'h027);
        checkOutput("full swap count", int'(Depth_Cnt), 8);
        checkOutput("full swap ovf", int'(Ovf_Err), 0);
        applyStimulus(1'b0, 1'b1, 12'h000);
        checkOutput("pop full swap", int'(PopDataOut), 12'h0CC);

`ifdef CALL_STACK_ERR_CLR_EN
        // Clear coincident with overflow loses; clear alone wins
        applyStimulus(1'b1, 1'b0, 12'h0DD);
        Err_Clr = 1'b1;
        applyStimulus(1'b1, 1'b0, 12'h0EE);
        checkOutput("clr vs ovf", int'(Ovf_Err), 1);
        applyStimulus(1'b0, 1'b0, 12'h000);
        Err_Clr = 1'b0;
        checkOutput("clr alone", int'(Ovf_Err), 0);
`endif

        @(negedge clk);
        #1 checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
